ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM pipeline register with branch/jump resolution for the 5-stage RV32I core, sitting directly downstream of the ALU. It captures the ALU result, ZeroFlag and EX-stage control, and forwards them to the MEM stage. It resolves taken branches, JAL and JALR into a registered redirect request to IF, using a valid/ready handshake. While a redirect is pending, it squashes wrong-path instructions and drives the pipeline flush.

## Interface
- No parameters (XLEN fixed at 32).
- `clk  in  1`: core clock; all state on its rising edge.
- `rstn  in  1`: asynchronous, active-low reset.
- `mem_stall  in  1`: data-memory wait; holds this register and all upstream stages.
- `ex_valid  in  1`: EX holds a real instruction.
- `ex_pc  in  32`: PC of the EX instruction.
- `ex_imm  in  32`: sign-extended immediate.
- `ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each`: instruction class; mutually exclusive.
- `alu_out  in  32`: ALU result. For JALR it is the target, with LSB already cleared.
- `zero_flag  in  1`: ALU branch-condition result (1 = taken).
- `ex_rs2_data  in  32`: forwarded store data.
- `ex_rd  in  5`, `ex_reg_write  in  1`, `ex_mem_read  in  1`, `ex_mem_write  in  1`, `ex_funct3  in  3`: control passed through to MEM.
- `mem_valid  out  1`, `mem_result  out  32`, `mem_rs2_data  out  32`, `mem_rd  out  5`, `mem_reg_write  out  1`, `mem_mem_read  out  1`, `mem_mem_write  out  1`, `mem_funct3  out  3`: registered MEM-stage payload.
- `redirect_valid  out  1`, `redirect_pc  out  32`: redirect request to IF.
- `redirect_ready  in  1`: IF accepts the redirect this cycle.
- `flush  out  1`: clears IF/ID and ID/EX. Equal to `redirect_valid`.
- `taken_cnt  out  32`: count of redirects issued; wraps at 2^32.

## Operation
- **State machine:** IDLE, PEND.
- **Capture.** The register captures on a rising edge when `mem_stall`=0.
  - `advance = !mem_stall`.
  - `live = ex_valid & (state==IDLE)`. In PEND, the EX content is wrong-path.
- **Fields written on capture:**
  - `mem_valid <= live`.
  - `mem_reg_write`, `mem_mem_read`, `mem_mem_write` are gated by `live`, so a squashed instruction has no side effects.
  - `mem_result <= (ex_is_jal|ex_is_jalr) ? ex_pc+4 : alu_out`, with 32-bit wrap.
  - `mem_rd`, `mem_funct3`, `mem_rs2_data` are copied unconditionally.
- **Taken condition:** `taken = live & advance & ((ex_is_branch & zero_flag) | ex_is_jal | ex_is_jalr)`.
- **Target:**
  - JALR: `{alu_out[31:1],1'b0}`.
  - Branch and JAL: `{(ex_pc+ex_imm)[31:1],1'b0}`, modulo 2^32.
- **IDLE → PEND on `taken`.** On that edge: `redirect_pc <= target`, `redirect_valid <= 1`, `taken_cnt <= taken_cnt+1`.
- **PEND → IDLE** on the edge where `redirect_ready`=1. `redirect_valid` deasserts on that edge.
  - PEND is left regardless of `mem_stall`; IF handshake progress is independent of MEM stalls.
- **While in PEND:**
  - `redirect_pc` is stable.
  - `flush`=1 every cycle.
  - Every capture produces a bubble.
- **Static prediction is not-taken.** A not-taken branch causes no redirect.
- **Reset mid-operation:**
  - All registers clear asynchronously.
  - A pending redirect is dropped.
  - The count is not incremented retroactively.

## Timing
- **Reset values:** all outputs 0. This includes `mem_valid`, `mem_result`, `redirect_valid`, `redirect_pc`, `flush` and `taken_cnt`. State = IDLE.
- **EX → MEM latency:** 1 cycle per advancing edge. Under `mem_stall`=1, all `mem_*` outputs hold indefinitely.
- **Redirect timing:**
  - `redirect_valid` rises on the same edge the branch/jump appears at `mem_valid`=1.
  - Minimum redirect occupancy is 1 cycle (`redirect_ready`=1 in the first PEND cycle).
  - Penalty: 2 squashed instructions plus one extra per cycle that `redirect_ready` is low.
- **Stall during capture:** a taken instruction held under `mem_stall` does not redirect until the edge it advances.
- **`flush`:** purely combinational from state, with no input-to-output path.
- **`taken_cnt`:** increments exactly once per IDLE→PEND transition.

## Test plan
- **Reset:** assert `rstn`=0 mid-PEND with `redirect_pc`=0x100 → all outputs 0 immediately. After release, IDLE with `taken_cnt`=0.
- **BEQ taken:** `ex_pc`=0x40, `ex_imm`=0x20, `zero_flag`=1 → next edge: `redirect_valid`=1, `redirect_pc`=0x60, `flush`=1.
  - With `redirect_ready` low for 3 cycles, 4 consecutive `mem_valid`=0 bubbles follow.
  - `taken_cnt`=1.
- **JALR:** `ex_pc`=0x80, `alu_out`=0x1234 → `redirect_pc`=0x1234, `mem_result`=0x84, `mem_reg_write`=1.
  - `redirect_ready`=1 the same cycle → IDLE after 1 cycle.
- **Not-taken branch:** `zero_flag`=0 → `mem_valid`=1, no redirect, and the next instruction captured with `mem_valid`=1.
- **Stall:** taken JAL arrives with `mem_stall`=1 for 2 cycles → no redirect and MEM outputs hold. Redirect to `ex_pc+ex_imm` occurs on the first unstalled edge. `mem_stall` asserted during PEND does not block the `redirect_ready` handshake.
- **Wrap:** `ex_pc`=0xFFFFFFFC JAL with `ex_imm`=8 → `redirect_pc`=0x4, `mem_result`=0x0. `taken_cnt` preset near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side payload in, MEM-side payload and IF redirect out.
// master = upstream/IF side, slave = the ex_mem_stage register.
interface ex_mem_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned F3W  = 3;

  logic            mem_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic [XLEN-1:0] alu_out;
  logic            zero_flag;
  logic [XLEN-1:0] ex_rs2_data;
  logic [RW-1:0]   ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [F3W-1:0]  ex_funct3;

  logic            mem_valid;
  logic [XLEN-1:0] mem_result;
  logic [XLEN-1:0] mem_rs2_data;
  logic [RW-1:0]   mem_rd;
  logic            mem_reg_write;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic [F3W-1:0]  mem_funct3;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flush;
  logic [XLEN-1:0] taken_cnt;

  modport master (
    output mem_stall, ex_valid, ex_pc, ex_imm, ex_is_branch, ex_is_jal, ex_is_jalr,
           alu_out, zero_flag, ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_funct3, redirect_ready,
    input  mem_valid, mem_result, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_funct3, redirect_valid, redirect_pc, flush, taken_cnt
  );

  modport slave (
    input  mem_stall, ex_valid, ex_pc, ex_imm, ex_is_branch, ex_is_jal, ex_is_jalr,
           alu_out, zero_flag, ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_funct3, redirect_ready,
    output mem_valid, mem_result, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_funct3, redirect_valid, redirect_pc, flush, taken_cnt
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/JAL/JALR resolution into a registered
// IF redirect request; squashes wrong-path instructions while the redirect pends.
module ex_mem_stage (
  input  logic          clk,
  input  logic          rstn,
  ex_mem_stage_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned F3W  = 3;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            advance_c;
  logic            live_c;
  logic            taken_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] link_c;
  logic [XLEN-1:0] br_sum_c;

  logic            mem_valid_q;
  logic [XLEN-1:0] mem_result_q;
  logic [XLEN-1:0] mem_rs2_data_q;
  logic [RW-1:0]   mem_rd_q;
  logic            mem_reg_write_q;
  logic            mem_mem_read_q;
  logic            mem_mem_write_q;
  logic [F3W-1:0]  mem_funct3_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [XLEN-1:0] taken_cnt_q;

  // Resolution: anything in EX while a redirect pends is wrong-path.
  always_comb begin
    advance_c = !bus.mem_stall;
    live_c    = bus.ex_valid && (state_q == IDLE);
    taken_c   = live_c && advance_c &&
                ((bus.ex_is_branch && bus.zero_flag) || bus.ex_is_jal || bus.ex_is_jalr);
    link_c    = bus.ex_pc + XLEN'(4);
    br_sum_c  = bus.ex_pc + bus.ex_imm;
    target_c  = bus.ex_is_jalr ? (bus.alu_out & ~XLEN'(1)) : (br_sum_c & ~XLEN'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // PEND exits on the IF handshake alone; MEM stalls do not hold it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (taken_c) state_d = PEND;
      PEND:    if (bus.redirect_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_valid_q     <= 1'b0;
      mem_result_q    <= '0;
      mem_rs2_data_q  <= '0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      mem_funct3_q    <= '0;
    end else if (advance_c) begin
      mem_valid_q     <= live_c;
      mem_result_q    <= (bus.ex_is_jal || bus.ex_is_jalr) ? link_c : bus.alu_out;
      mem_rs2_data_q  <= bus.ex_rs2_data;
      mem_rd_q        <= bus.ex_rd;
      mem_reg_write_q <= bus.ex_reg_write && live_c;
      mem_mem_read_q  <= bus.ex_mem_read && live_c;
      mem_mem_write_q <= bus.ex_mem_write && live_c;
      mem_funct3_q    <= bus.ex_funct3;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_pc_q <= '0;
      taken_cnt_q   <= '0;
    end else if (taken_c) begin
      redirect_pc_q <= target_c;
      taken_cnt_q   <= taken_cnt_q + XLEN'(1);
    end
  end

  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_result     = mem_result_q;
  assign bus.mem_rs2_data   = mem_rs2_data_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_reg_write  = mem_reg_write_q;
  assign bus.mem_mem_read   = mem_mem_read_q;
  assign bus.mem_mem_write  = mem_mem_write_q;
  assign bus.mem_funct3     = mem_funct3_q;
  assign bus.redirect_valid = (state_q == PEND);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = (state_q == PEND);
  assign bus.taken_cnt      = taken_cnt_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_ex_mem_stage;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  ex_mem_stage_if bus ();

  ex_mem_stage u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what MEM and IF should observe after each edge.
  logic        m_valid, m_rw, m_mr, m_mw, m_pend;
  logic [31:0] m_result, m_rs2, m_rpc, m_cnt;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_pend = 0;
    m_result = 0; m_rs2 = 0; m_rpc = 0; m_cnt = 0; m_rd = 0; m_f3 = 0;
  endtask

  // One instruction-level step using the inputs present before the edge.
  task automatic model_edge();
    logic        in_order, is_jump, redirect;
    logic [31:0] dest;
    in_order = bus.ex_valid && !m_pend;
    is_jump  = bus.ex_is_jal || bus.ex_is_jalr;
    redirect = in_order && !bus.mem_stall && ((bus.ex_is_branch && bus.zero_flag) || is_jump);
    dest     = bus.ex_is_jalr ? bus.alu_out : bus.ex_pc + bus.ex_imm;
    dest[0]  = 1'b0;
    if (!bus.mem_stall) begin
      m_valid  = in_order;
      m_result = is_jump ? bus.ex_pc + 32'd4 : bus.alu_out;
      m_rs2    = bus.ex_rs2_data;
      m_rd     = bus.ex_rd;
      m_f3     = bus.ex_funct3;
      m_rw     = in_order && bus.ex_reg_write;
      m_mr     = in_order && bus.ex_mem_read;
      m_mw     = in_order && bus.ex_mem_write;
    end
    if (m_pend) begin
      if (bus.redirect_ready) m_pend = 0;
    end else if (redirect) begin
      m_pend = 1;
      m_rpc  = dest;
      m_cnt  = m_cnt + 32'd1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mem_valid"},      32'(bus.mem_valid),      32'(m_valid));
    check({tag, ".mem_result"},     bus.mem_result,          m_result);
    check({tag, ".mem_rs2_data"},   bus.mem_rs2_data,        m_rs2);
    check({tag, ".mem_rd"},         32'(bus.mem_rd),         32'(m_rd));
    check({tag, ".mem_funct3"},     32'(bus.mem_funct3),     32'(m_f3));
    check({tag, ".mem_reg_write"},  32'(bus.mem_reg_write),  32'(m_rw));
    check({tag, ".mem_mem_read"},   32'(bus.mem_mem_read),   32'(m_mr));
    check({tag, ".mem_mem_write"},  32'(bus.mem_mem_write),  32'(m_mw));
    check({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(m_pend));
    check({tag, ".redirect_pc"},    bus.redirect_pc,         m_rpc);
    check({tag, ".flush"},          32'(bus.flush),          32'(m_pend));
    check({tag, ".taken_cnt"},      bus.taken_cnt,           m_cnt);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                       input int kind, input logic [31:0] alu, input logic zf);
    bus.ex_valid     = v;
    bus.ex_pc        = pc;
    bus.ex_imm       = imm;
    bus.ex_is_branch = (kind == 1);
    bus.ex_is_jal    = (kind == 2);
    bus.ex_is_jalr   = (kind == 3);
    bus.alu_out      = alu;
    bus.zero_flag    = zf;
    bus.ex_rs2_data  = $urandom;
    bus.ex_rd        = 5'($urandom);
    bus.ex_funct3    = 3'($urandom);
    bus.ex_reg_write = 1'($urandom);
    bus.ex_mem_read  = 1'($urandom);
    bus.ex_mem_write = 1'($urandom);
  endtask

  int bubbles;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    bus.mem_stall      = 1'b0;
    bus.redirect_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    model_reset();
    #2;
    check_all("reset");
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // BEQ taken, IF slow to accept for 3 cycles
    drive(1'b1, 32'h40, 32'h20, 1, 32'h0, 1'b1);
    step("beq");
    check("beq.rpc", bus.redirect_pc, 32'h60);
    check("beq.flush", 32'(bus.flush), 32'd1);
    check("beq.cnt", bus.taken_cnt, 32'd1);
    bubbles = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h44 + 32'(4 * i), 32'h0, 0, 32'h11, 1'b0);
      bus.redirect_ready = (i == 3);
      step("beq_pend");
      if (!bus.mem_valid) bubbles++;
    end
    check("beq.bubbles", 32'(bubbles), 32'd4);
    bus.redirect_ready = 1'b0;

    // JALR accepted in its first PEND cycle
    drive(1'b1, 32'h80, 32'h0, 3, 32'h1234, 1'b0);
    bus.ex_reg_write = 1'b1;
    step("jalr");
    check("jalr.rpc", bus.redirect_pc, 32'h1234);
    check("jalr.result", bus.mem_result, 32'h84);
    check("jalr.reg_write", 32'(bus.mem_reg_write), 32'd1);
    bus.redirect_ready = 1'b1;
    drive(1'b1, 32'h84, 32'h0, 0, 32'h5, 1'b0);
    step("jalr_ack");
    check("jalr.idle", 32'(bus.redirect_valid), 32'd0);
    bus.redirect_ready = 1'b0;

    // Not-taken branch followed by a normal instruction
    drive(1'b1, 32'h100, 32'h40, 1, 32'h77, 1'b0);
    step("bne");
    check("bne.valid", 32'(bus.mem_valid), 32'd1);
    check("bne.noredir", 32'(bus.redirect_valid), 32'd0);
    drive(1'b1, 32'h104, 32'h0, 0, 32'h88, 1'b0);
    step("bne_next");
    check("bne_next.valid", 32'(bus.mem_valid), 32'd1);

    // Taken JAL held by a MEM stall for 2 cycles
    drive(1'b1, 32'h200, 32'h30, 2, 32'h0, 1'b0);
    bus.mem_stall = 1'b1;
    step("stall1");
    step("stall2");
    check("stall.noredir", 32'(bus.redirect_valid), 32'd0);
    check("stall.hold", bus.mem_result, 32'h88);
    bus.mem_stall = 1'b0;
    step("stall_go");
    check("stall.rpc", bus.redirect_pc, 32'h230);
    bus.mem_stall = 1'b1;
    bus.redirect_ready = 1'b1;
    step("stall_ack");
    check("stall.ack", 32'(bus.redirect_valid), 32'd0);
    bus.mem_stall = 1'b0;
    bus.redirect_ready = 1'b1;

    // Address wrap
    drive(1'b1, 32'hFFFF_FFFC, 32'h8, 2, 32'h0, 1'b0);
    step("wrap");
    check("wrap.rpc", bus.redirect_pc, 32'h4);
    check("wrap.result", bus.mem_result, 32'h0);
    step("wrap_ack");

    // Reset while a redirect to 0x100 is pending
    bus.redirect_ready = 1'b0;
    drive(1'b1, 32'hF0, 32'h10, 2, 32'h0, 1'b0);
    step("pre_rst");
    check("pre_rst.rpc", bus.redirect_pc, 32'h100);
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    step("post_rst");
    check("post_rst.cnt", bus.taken_cnt, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] alu;
      int kind;
      kind = int'($urandom_range(0, 3));
      alu  = $urandom;
      if (kind == 3) alu[0] = 1'b0;
      drive(($urandom_range(0, 9) < 8), $urandom, $urandom, kind, alu, 1'($urandom));
      bus.mem_stall      = ($urandom_range(0, 3) == 0);
      bus.redirect_ready = 1'($urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
